// File: rtl/argmax_stream_ctrl_if.sv
// argmax_stream_ctrl_if: job, bid stream, engine and result signals of the argmax stream controller
// Ports (slave = controller view):
//   start/cfg_count in, busy/err_zero out            job control
//   bid_valid/bid_data in, bid_ready out             bid stream
//   arg_bids/arg_in_valid out, arg_out_valid/arg_win in   argmax10 engine
//   res_ready in, res_valid/res_index/res_bid out    result
interface argmax_stream_ctrl_if #(
  parameter int bW = 17,
  parameter int IW = 8
);
  logic           start;
  logic [IW-1:0]  cfg_count;
  logic           busy;
  logic           err_zero;
  logic           bid_valid;
  logic           bid_ready;
  logic [bW-1:0]  bid_data;
  logic [10*bW-1:0] arg_bids;
  logic           arg_in_valid;
  logic           arg_out_valid;
  logic [3:0]     arg_win;
  logic           res_valid;
  logic           res_ready;
  logic [IW-1:0]  res_index;
  logic [bW-1:0]  res_bid;
  modport slave (
    input  start, cfg_count, bid_valid, bid_data, arg_out_valid, arg_win, res_ready,
    output busy, err_zero, bid_ready, arg_bids, arg_in_valid, res_valid, res_index, res_bid
  );
  modport master (
    output start, cfg_count, bid_valid, bid_data, arg_out_valid, arg_win, res_ready,
    input  busy, err_zero, bid_ready, arg_bids, arg_in_valid, res_valid, res_index, res_bid
  );
endinterface

// File: rtl/argmax_stream_ctrl.sv
// argmax_stream_ctrl: streams bids in groups of up to 10 through an argmax10 engine and keeps the global maximum
// Ports: clk, rst_n (sync, active-low), bus (argmax_stream_ctrl_if.slave: job, bid stream, engine, result)
module argmax_stream_ctrl #(
  parameter int bW = 17,
  parameter int IW = 8
) (
  input logic clk,
  input logic rst_n,
  argmax_stream_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FILL, LAUNCH, WAIT, DONE} state_t;
  state_t        r_state;
  logic [bW-1:0] r_slot [10];
  logic [3:0]    r_fill;
  logic [IW-1:0] r_remaining, r_base, r_best_idx;
  logic [bW-1:0] r_best_bid;
  logic          r_have_best, r_busy, r_bid_ready, r_arg_in_valid, r_res_valid, r_err_zero;
  logic [3:0]    w_win;
  logic [bW-1:0] w_cand;
  logic          w_take;
  logic [10*bW-1:0] w_bids;
  // a winner pointing at a padding slot is folded back to slot 0, which holds the same value
  always_comb begin
    w_win = (bus.arg_win >= r_fill) ? 4'd0 : bus.arg_win;
    w_cand = r_slot[w_win];
    w_take = !r_have_best || (w_cand > r_best_bid);
    w_bids = '0;
    for (int k = 0; k < 10; k++) w_bids[k*bW +: bW] = (4'(k) < r_fill) ? r_slot[k] : r_slot[0];
  end
  assign bus.arg_bids     = w_bids;
  assign bus.busy         = r_busy;
  assign bus.bid_ready    = r_bid_ready;
  assign bus.arg_in_valid = r_arg_in_valid;
  assign bus.res_valid    = r_res_valid;
  assign bus.err_zero     = r_err_zero;
  assign bus.res_index    = r_best_idx;
  assign bus.res_bid      = r_best_bid;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_slot         <= '{default: '0};
      r_fill         <= '0;
      r_remaining    <= '0;
      r_base         <= '0;
      r_best_idx     <= '0;
      r_best_bid     <= '0;
      r_have_best    <= 1'b0;
      r_busy         <= 1'b0;
      r_bid_ready    <= 1'b0;
      r_arg_in_valid <= 1'b0;
      r_res_valid    <= 1'b0;
      r_err_zero     <= 1'b0;
    end else begin
      r_err_zero <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          if (bus.cfg_count == '0) r_err_zero <= 1'b1;
          else begin
            r_state     <= FILL;
            r_remaining <= bus.cfg_count;
            r_base      <= '0;
            r_fill      <= '0;
            r_have_best <= 1'b0;
            r_busy      <= 1'b1;
            r_bid_ready <= 1'b1;
          end
        end
        FILL: if (bus.bid_valid) begin
          r_slot[r_fill] <= bus.bid_data;
          r_fill         <= r_fill + 4'd1;
          r_remaining    <= r_remaining - IW'(1);
          if (r_fill == 4'd9 || r_remaining == IW'(1)) begin
            r_state        <= LAUNCH;
            r_bid_ready    <= 1'b0;
            r_arg_in_valid <= 1'b1;
          end
        end
        LAUNCH: begin
          r_arg_in_valid <= 1'b0;
          r_state        <= WAIT;
        end
        WAIT: if (bus.arg_out_valid) begin
          if (w_take) begin
            r_best_bid  <= w_cand;
            r_best_idx  <= r_base + IW'(w_win);
            r_have_best <= 1'b1;
          end
          if (r_remaining == '0) begin
            r_state     <= DONE;
            r_res_valid <= 1'b1;
          end else begin
            r_base      <= r_base + IW'(r_fill);
            r_fill      <= '0;
            r_state     <= FILL;
            r_bid_ready <= 1'b1;
          end
        end
        DONE: if (bus.res_ready) begin
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_argmax_stream_ctrl.sv
// tb_argmax_stream_ctrl: directed scenarios against argmax_stream_ctrl with a behavioural argmax10 engine
module tb_argmax_stream_ctrl;
  localparam int bW = 17;
  localparam int IW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0, n_chk = 0, n_pass = 0, n_launch = 0, eng_lat = 1, eng_force = -1;
  bit chk_stable = 1'b1;
  logic [bW-1:0] snap [10];
  logic [10*bW-1:0] snap_bus;
  argmax_stream_ctrl_if #(.bW(bW), .IW(IW)) bus ();
  argmax_stream_ctrl #(.bW(bW), .IW(IW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // engine: first-maximum argmax of the launched slots, answered eng_lat cycles after the launch
  initial begin
    logic [3:0] win;
    bus.arg_out_valid = 1'b0;
    bus.arg_win = '0;
    forever begin
      @(negedge clk);
      if (bus.arg_in_valid === 1'b1) begin
        snap_bus = bus.arg_bids;
        for (int k = 0; k < 10; k++) snap[k] = snap_bus[k*bW +: bW];
        win = 4'd0;
        for (int k = 1; k < 10; k++) if (snap[k] > snap[win]) win = 4'(k);
        if (eng_force >= 0) win = 4'(eng_force);
        n_launch++;
        repeat (eng_lat) @(posedge clk);
        #1 bus.arg_out_valid = 1'b1;
        bus.arg_win = win;
        @(negedge clk);
        if (chk_stable) begin
          n_chk++;
          if (bus.arg_bids !== snap_bus) $display("FAIL arg_bids_stable got %h want %h", bus.arg_bids, snap_bus);
          else n_pass++;
        end
        @(posedge clk);
        #1 bus.arg_out_valid = 1'b0;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  task automatic start_job(input int n, output int t);
    bus.start = 1'b1;
    bus.cfg_count = n[IW-1:0];
    t = cyc;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic push(input int d);
    int k;
    bus.bid_valid = 1'b1;
    bus.bid_data = d[bW-1:0];
    k = 0;
    @(negedge clk);
    while (bus.bid_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      n_chk++;
      $display("FAIL push_timeout bid_ready got %b want 1", bus.bid_ready);
    end
    @(posedge clk);
    #1 bus.bid_valid = 1'b0;
  endtask
  task automatic get_result(input string nm, input int eidx, input int ebid, input int t0, input int elat, input int hold);
    int k;
    k = 0;
    @(negedge clk);
    while (bus.res_valid !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) begin
      n_chk++;
      $display("FAIL %s_timeout res_valid got %b want 1", nm, bus.res_valid);
    end
    if (elat >= 0) begin
      n_chk++;
      if (cyc - t0 !== elat) $display("FAIL %s_latency got %0d want %0d", nm, cyc - t0, elat);
      else n_pass++;
    end
    n_chk++;
    if (bus.res_index !== eidx[IW-1:0]) $display("FAIL %s_index got %0d want %0d", nm, bus.res_index, eidx);
    else n_pass++;
    n_chk++;
    if (bus.res_bid !== ebid[bW-1:0]) $display("FAIL %s_bid got %0d want %0d", nm, bus.res_bid, ebid);
    else n_pass++;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_chk++;
      if (bus.res_valid !== 1'b1 || bus.res_index !== eidx[IW-1:0] || bus.res_bid !== ebid[bW-1:0])
        $display("FAIL %s_hold got v=%b i=%0d b=%0d want v=1 i=%0d b=%0d", nm, bus.res_valid, bus.res_index, bus.res_bid, eidx, ebid);
      else n_pass++;
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    n_chk++;
    if ({bus.res_valid, bus.busy} !== 2'b00) $display("FAIL %s_accept got valid,busy=%b want 00", nm, {bus.res_valid, bus.busy});
    else n_pass++;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_chk++;
    if ({bus.busy, bus.bid_ready, bus.arg_in_valid, bus.res_valid, bus.err_zero} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000", {bus.busy, bus.bid_ready, bus.arg_in_valid, bus.res_valid, bus.err_zero});
    else n_pass++;
    n_chk++;
    if ({bus.res_index, bus.res_bid} !== '0) $display("FAIL reset_result got %0d/%0d want 0/0", bus.res_index, bus.res_bid);
    else n_pass++;
    n_chk++;
    if (bus.arg_bids !== '0) $display("FAIL reset_arg_bids got %h want 0", bus.arg_bids);
    else n_pass++;
  endtask
  task automatic test_single_group();
    int v[10] = '{5, 9, 3, 9, 1, 0, 2, 7, 8, 4};
    int t, l0;
    l0 = n_launch;
    start_job(10, t);
    for (int i = 0; i < 10; i++) push(v[i]);
    get_result("single", 1, 9, t, 13, 0);
    n_chk++;
    if (n_launch - l0 !== 1) $display("FAIL single_launches got %0d want 1", n_launch - l0);
    else n_pass++;
  endtask
  task automatic test_multi_group();
    int t, l0;
    l0 = n_launch;
    start_job(23, t);
    for (int i = 0; i < 23; i++) push(i == 17 ? 1000 : i);
    get_result("multi", 17, 1000, t, 30, 0);
    n_chk++;
    if (n_launch - l0 !== 3) $display("FAIL multi_launches got %0d want 3", n_launch - l0);
    else n_pass++;
    n_chk++;
    if (snap[2] !== bW'(22)) $display("FAIL multi_last_slot got %0d want 22", snap[2]);
    else n_pass++;
    n_chk++;
    if (snap[3] !== bW'(20) || snap[9] !== bW'(20)) $display("FAIL multi_padding got %0d,%0d want 20,20", snap[3], snap[9]);
    else n_pass++;
  endtask
  task automatic test_remap();
    int t;
    eng_force = 9;
    start_job(3, t);
    for (int i = 0; i < 3; i++) push(0);
    get_result("remap_zero", 0, 0, t, -1, 0);
    start_job(3, t);
    push(4);
    push(6);
    push(2);
    get_result("remap_val", 0, 4, t, -1, 0);
    eng_force = -1;
  endtask
  task automatic test_tie_ignored_start();
    int t, l0;
    eng_lat = 3;
    l0 = n_launch;
    start_job(20, t);
    for (int i = 0; i < 20; i++) begin
      if (i == 5 || i == 12) begin
        bus.start = 1'b1;
        bus.cfg_count = (i == 5) ? IW'(0) : IW'(3);
      end
      push((i == 4 || i == 14) ? 50 : i % 10);
      bus.start = 1'b0;
      if (i == 5) begin
        n_chk++;
        if ({bus.err_zero, bus.busy} !== 2'b01) $display("FAIL fill_start got err,busy=%b want 01", {bus.err_zero, bus.busy});
        else n_pass++;
      end
    end
    n_chk++;
    if (bus.bid_ready !== 1'b0) $display("FAIL ready_after_last got %b want 0", bus.bid_ready);
    else n_pass++;
    get_result("tie", 4, 50, t, -1, 0);
    n_chk++;
    if (n_launch - l0 !== 2) $display("FAIL tie_launches got %0d want 2", n_launch - l0);
    else n_pass++;
    eng_lat = 1;
  endtask
  task automatic test_zero_start();
    int t;
    start_job(0, t);
    n_chk++;
    if ({bus.err_zero, bus.busy, bus.bid_ready} !== 3'b100) $display("FAIL zero_pulse got err,busy,ready=%b want 100", {bus.err_zero, bus.busy, bus.bid_ready});
    else n_pass++;
    @(posedge clk);
    #1;
    n_chk++;
    if ({bus.err_zero, bus.busy} !== 2'b00) $display("FAIL zero_pulse_end got err,busy=%b want 00", {bus.err_zero, bus.busy});
    else n_pass++;
  endtask
  task automatic test_reset_midjob();
    int t;
    eng_lat = 6;
    chk_stable = 1'b0;
    start_job(10, t);
    for (int i = 0; i < 10; i++) push(30 + i);
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (bus.busy !== 1'b1) $display("FAIL wait_busy got %b want 1", bus.busy);
    else n_pass++;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    n_chk++;
    if ({bus.busy, bus.bid_ready, bus.arg_in_valid, bus.res_valid} !== 4'b0)
      $display("FAIL midjob_reset got %b want 0000", {bus.busy, bus.bid_ready, bus.arg_in_valid, bus.res_valid});
    else n_pass++;
    repeat (8) @(posedge clk);
    #1;
    n_chk++;
    if ({bus.busy, bus.res_valid} !== 2'b00) $display("FAIL late_engine got busy,valid=%b want 00", {bus.busy, bus.res_valid});
    else n_pass++;
    eng_lat = 1;
    chk_stable = 1'b1;
    start_job(1, t);
    repeat (3) @(posedge clk);
    #1 push(7);
    get_result("after_reset", 0, 7, t, -1, 5);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.cfg_count = '0;
    bus.bid_valid = 1'b0;
    bus.bid_data = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_single_group();
    test_multi_group();
    test_remap();
    test_tie_ignored_start();
    test_zero_start();
    test_reset_midjob();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
